instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Producer side of the opcode/control interface: holds the PC, owns instruction memory and issues the
//  current instruction (and its opcode) to the main control decoder each cycle. Consumes the decoded
//  branch/jump/halt controls plus ALU zero to pick the next PC. Also provides a program-load handshake
//  used by the testbench/loader before execution. Single-cycle CPU: one instruction per clock in RUN.
// PARAMETERS
//  ADDR_W   8         word-address bits of instruction memory (depth 2**ADDR_W words)
//  RESET_PC 32'h0     byte address of first instruction; bits [1:0] forced to 0
// PORTS
//  clk          in   1       system clock, all state on rising edge
//  rst          in   1       synchronous, active-high reset
//  load_valid   in   1       loader write request (LOAD state only)
//  load_ready   out  1       1 while in LOAD
//  load_addr    in   ADDR_W  word address of load write
//  load_data    in   32      instruction word to write
//  load_done    in   1       end of program load; start execution
//  branch       in   1       from control decoder (BEQ)
//  jump         in   1       from control decoder (J)
//  halt         in   1       from control decoder (opcode 6'b111111)
//  zero         in   1       ALU zero flag
//  instr        out  32      current instruction word
//  opcode       out  6       instr[31:26], to control decoder
//  pc           out  32      current PC (byte address)
//  pc_plus4     out  32      pc + 4
//  instr_valid  out  1       1 only in RUN
//  halted       out  1       1 only in HALTED
//  cycle_count  out  32      executed-instruction count
// BEHAVIOUR
//  - FSM: LOAD -> RUN -> HALTED. Reset: state=LOAD, pc=RESET_PC, cycle_count=0, load_ready=1,
//    instr_valid=0, halted=0. Memory array is NOT reset; contents survive rst.
//  - LOAD: write imem[load_addr]=load_data when load_valid&&load_ready. load_done -> RUN next cycle,
//    pc=RESET_PC; a write in the same cycle as load_done still completes.
//  - instr = imem[pc[ADDR_W+1:2]], combinational (async read), valid in RUN; pc upper bits alias.
//  - RUN next-PC, priority halt > jump > branch&&zero > sequential:
//      halt        : ->HALTED, pc holds
//      jump        : pc = {pc_plus4[31:28], instr[25:0], 2'b00}
//      branch&zero : pc = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00}
//      otherwise   : pc = pc_plus4 (includes branch&&!zero and unknown opcodes)
//  - 32-bit PC arithmetic wraps modulo 2**32; no overflow flag.
//  - cycle_count: +1 every RUN cycle incl. the halt cycle; saturates at 32'hFFFF_FFFF.
//  - HALTED: pc, cycle_count frozen; instr_valid=0, halted=1, load_ready=0; exits only on rst.
//  - branch/jump/halt/zero ignored outside RUN; load_* ignored outside LOAD.
//  - rst in any state (mid-load, mid-run, halted) -> reset values next cycle; rst wins over all inputs.
// STRUCTURE
//  - Shared package/header: opcode constants OP_RTYPE 6'h00, OP_J 6'h02, OP_BEQ 6'h04, OP_ADDI 6'h08,
//    OP_SUBI 6'h09, OP_LW 6'h23, OP_SW 6'h2B, OP_HALT 6'h3F; FSM state encoding (LOAD/RUN/HALTED).
//  - One sub-module: imem_ram (1 sync write port, 1 async read port, depth 2**ADDR_W x 32).
//  - Next-PC mux and FSM live in this module.
// TESTING
//  1. rst; load 0x20080005,0x20090003,0xFC000000 at 0..2; load_done -> pc=0, opcode=6'h08,
//     instr_valid=1, load_ready=0.
//  2. Sequential run, controls 0 -> pc 0,4,8 on successive cycles; cycle_count 0,1,2.
//  3. pc=8, instr=0x1000FFFE, branch=1 zero=1 -> pc=0x4; repeat with zero=0 -> pc=0xC.
//  4. pc=0x10, instr=0x08000010, jump=1 -> pc=0x40; halt=1 with jump=1 -> HALTED, pc stays 0x10.
//  5. In HALTED: load_valid=1, branch=1 for 5 cycles -> pc, cycle_count unchanged, halted=1,
//     instr_valid=0, memory unchanged.
//  6. rst mid-RUN at pc=0x8 -> LOAD, pc=0, count=0; load_done with no writes -> instr=0x20080005.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg: opcode constants and fetch FSM state encoding
package instr_fetch_unit_pkg;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SUBI  = 6'h09;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;
    typedef enum logic [1:0] {ST_LOAD, ST_RUN, ST_HALTED} state_t;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: loader handshake, decoder controls and fetched-instruction bus
interface instr_fetch_unit_if #(parameter int ADDR_W = 8);
    logic              load_valid;
    logic              load_ready;
    logic [ADDR_W-1:0] load_addr;
    logic [31:0]       load_data;
    logic              load_done;
    logic              branch;
    logic              jump;
    logic              halt;
    logic              zero;
    logic [31:0]       instr;
    logic [5:0]        opcode;
    logic [31:0]       pc;
    logic [31:0]       pc_plus4;
    logic              instr_valid;
    logic              halted;
    logic [31:0]       cycle_count;
    modport master (
        input  load_valid, load_addr, load_data, load_done, branch, jump, halt, zero,
        output load_ready, instr, opcode, pc, pc_plus4, instr_valid, halted, cycle_count
    );
    modport slave (
        output load_valid, load_addr, load_data, load_done, branch, jump, halt, zero,
        input  load_ready, instr, opcode, pc, pc_plus4, instr_valid, halted, cycle_count
    );
endinterface

// File: rtl/imem_ram.sv
// imem_ram: instruction memory, one synchronous write port and one asynchronous read port
module imem_ram #(parameter int ADDR_W = 8) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);
    logic [31:0] mem [2**ADDR_W];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC, instruction memory and LOAD/RUN/HALTED sequencing for a single-cycle CPU
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input logic                clk,
    input logic                rst,
    instr_fetch_unit_if.master bus
);
    localparam logic [31:0] START_PC = {RESET_PC[31:2], 2'b00};
    state_t      state, state_nx;
    logic [31:0] pc, pc_plus4, pc_nx, instr, cycle_count;
    logic        load_ready, instr_valid, halted, we;

    assign we = bus.load_valid && load_ready;

    imem_ram #(.ADDR_W(ADDR_W)) u_imem (
        .clk   (clk),
        .we    (we),
        .waddr (bus.load_addr),
        .wdata (bus.load_data),
        .raddr (pc[ADDR_W+1:2]),
        .rdata (instr)
    );

    always_ff @(posedge clk)
        if (rst) state <= ST_LOAD;
        else     state <= state_nx;

    always_comb begin
        state_nx = (state == ST_LOAD && bus.load_done) ? ST_RUN :
                   (state == ST_RUN && bus.halt)       ? ST_HALTED : state;
    end

    always_comb begin
        load_ready  = state == ST_LOAD;
        instr_valid = state == ST_RUN;
        halted      = state == ST_HALTED;
    end

    assign pc_plus4 = pc + 32'd4;

    // Priority: halt > jump > taken branch > sequential
    always_comb begin
        pc_nx = bus.halt                  ? pc :
                bus.jump                  ? {pc_plus4[31:28], instr[25:0], 2'b00} :
                (bus.branch && bus.zero)  ? pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00} :
                                            pc_plus4;
    end

    always_ff @(posedge clk)
        if (rst) begin
            pc          <= START_PC;
            cycle_count <= '0;
        end else begin
            if (state == ST_LOAD && bus.load_done) pc <= START_PC;
            else if (state == ST_RUN)              pc <= pc_nx;
            if (state == ST_RUN && cycle_count != '1) cycle_count <= cycle_count + 32'd1;
        end

    assign bus.load_ready  = load_ready;
    assign bus.instr       = instr;
    assign bus.opcode      = instr[31:26];
    assign bus.pc          = pc;
    assign bus.pc_plus4    = pc_plus4;
    assign bus.instr_valid = instr_valid;
    assign bus.halted      = halted;
    assign bus.cycle_count = cycle_count;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: table-driven run vectors with a next-PC/count scoreboard plus load/halt/reset sequences
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    typedef struct {
        logic        br, jp, ht, z;
        logic [31:0] pc, instr, pc_nx, cnt_nx;
    } vec_t;
    typedef struct {
        logic [31:0] pc, cnt;
    } exp_t;
    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } ld_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];

    instr_fetch_unit_if #(.ADDR_W(8)) bus ();
    instr_fetch_unit #(.ADDR_W(8), .RESET_PC(32'h0)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ctrl(input logic br, input logic jp, input logic ht, input logic z);
        bus.branch = br;
        bus.jump   = jp;
        bus.halt   = ht;
        bus.zero   = z;
    endtask

    vec_t vecs[13];
    ld_t  prog[7];

    initial begin
        prog[0] = '{8'd0,  32'h2008_0005};
        prog[1] = '{8'd1,  32'h2009_0003};
        prog[2] = '{8'd2,  32'hFC00_0000};
        prog[3] = '{8'd2,  32'h1000_FFFE};
        prog[4] = '{8'd3,  32'h0000_0000};
        prog[5] = '{8'd4,  32'h0800_0010};
        prog[6] = '{8'd16, 32'hFC00_0000};
        //            br    jp    ht    z     pc      instr          pc_nx   cnt_nx
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 32'h2008_0005, 32'h04, 32'd1};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h04, 32'h2009_0003, 32'h08, 32'd2};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h08, 32'h1000_FFFE, 32'h04, 32'd3};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h04, 32'h2009_0003, 32'h08, 32'd4};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h08, 32'h1000_FFFE, 32'h0C, 32'd5};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0C, 32'h0000_0000, 32'h10, 32'd6};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0800_0010, 32'h40, 32'd7};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'hFC00_0000, 32'h00, 32'd8};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h00, 32'h2008_0005, 32'h04, 32'd9};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h04, 32'h2009_0003, 32'h08, 32'd10};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h08, 32'h1000_FFFE, 32'h0C, 32'd11};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0C, 32'h0000_0000, 32'h10, 32'd12};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0800_0010, 32'h10, 32'd13};

        bus.load_valid = 1'b0;
        bus.load_addr  = '0;
        bus.load_data  = '0;
        bus.load_done  = 1'b0;
        ctrl(1'b0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        rst = 1'b0;
        chk("rst_load_ready", {31'd0, bus.load_ready}, 32'd1);
        chk("rst_instr_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("rst_halted", {31'd0, bus.halted}, 32'd0);
        chk("rst_pc", bus.pc, 32'h0);
        chk("rst_count", bus.cycle_count, 32'd0);

        // Program load; the final write shares its cycle with load_done
        foreach (prog[i]) begin
            bus.load_valid = 1'b1;
            bus.load_addr  = prog[i].addr;
            bus.load_data  = prog[i].data;
            bus.load_done  = (i == 6);
            step();
        end
        bus.load_valid = 1'b0;
        bus.load_done  = 1'b0;
        chk("run_pc", bus.pc, 32'h0);
        chk("run_opcode", {26'd0, bus.opcode}, {26'd0, OP_ADDI});
        chk("run_instr_valid", {31'd0, bus.instr_valid}, 32'd1);
        chk("run_load_ready", {31'd0, bus.load_ready}, 32'd0);
        chk("run_count", bus.cycle_count, 32'd0);

        foreach (vecs[i]) begin
            ctrl(vecs[i].br, vecs[i].jp, vecs[i].ht, vecs[i].z);
            chk($sformatf("v%0d_pc", i), bus.pc, vecs[i].pc);
            chk($sformatf("v%0d_instr", i), bus.instr, vecs[i].instr);
            chk($sformatf("v%0d_opcode", i), {26'd0, bus.opcode}, {26'd0, vecs[i].instr[31:26]});
            chk($sformatf("v%0d_pc_plus4", i), bus.pc_plus4, vecs[i].pc + 32'd4);
            sbq.push_back('{vecs[i].pc_nx, vecs[i].cnt_nx});
            step();
            begin
                exp_t e;
                e = sbq.pop_front();
                chk($sformatf("v%0d_pc_next", i), bus.pc, e.pc);
                chk($sformatf("v%0d_count", i), bus.cycle_count, e.cnt);
            end
        end
        chk("halt_halted", {31'd0, bus.halted}, 32'd1);
        chk("halt_instr_valid", {31'd0, bus.instr_valid}, 32'd0);

        // HALTED ignores loader and decoder inputs
        bus.load_valid = 1'b1;
        bus.load_addr  = 8'd0;
        bus.load_data  = 32'hDEAD_BEEF;
        ctrl(1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("hlt_pc", bus.pc, 32'h10);
            chk("hlt_count", bus.cycle_count, 32'd13);
            chk("hlt_halted", {31'd0, bus.halted}, 32'd1);
            chk("hlt_instr_valid", {31'd0, bus.instr_valid}, 32'd0);
            chk("hlt_load_ready", {31'd0, bus.load_ready}, 32'd0);
        end
        bus.load_valid = 1'b0;
        ctrl(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset from HALTED, run to pc=8, then reset mid-RUN with a jump asserted
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rh_halted", {31'd0, bus.halted}, 32'd0);
        chk("rh_instr_mem", bus.instr, 32'h2008_0005);
        bus.load_done = 1'b1;
        step();
        bus.load_done = 1'b0;
        step();
        step();
        chk("mr_pc", bus.pc, 32'h8);
        chk("mr_count", bus.cycle_count, 32'd2);
        rst = 1'b1;
        ctrl(1'b0, 1'b1, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        ctrl(1'b0, 1'b0, 1'b0, 1'b0);
        chk("mr_rst_pc", bus.pc, 32'h0);
        chk("mr_rst_count", bus.cycle_count, 32'd0);
        chk("mr_rst_load_ready", {31'd0, bus.load_ready}, 32'd1);
        chk("mr_rst_instr_valid", {31'd0, bus.instr_valid}, 32'd0);
        bus.load_done = 1'b1;
        step();
        bus.load_done = 1'b0;
        chk("rl_instr", bus.instr, 32'h2008_0005);
        chk("rl_instr_valid", {31'd0, bus.instr_valid}, 32'd1);
        chk("rl_pc", bus.pc, 32'h0);
        step();
        chk("rl_pc_next", bus.pc, 32'h4);
        chk("rl_count", bus.cycle_count, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
